// File: rtl/ate_bin_packer.sv
// ate_bin_packer
// Packs the binarised pixel stream of the adaptive threshold engine into
// bytes, MSB first. Each byte is tagged with its frame-relative byte address
// and with the threshold seen alongside its 8th bin, then held in a small
// FIFO. The FIFO drains to the result-memory writer over valid/ready.
//
// Ports:
//   clk, CAL_reset        clock, asynchronous active-low reset
//   in_valid, sof, bin    pixel stream (sof is meaningful only with in_valid)
//   threshold[7:0]        engine threshold for the current pixel
//   out_valid, out_ready  FIFO head handshake
//   out_data[7:0]         packed byte, first pixel in bit 7
//   out_addr[ADDR_W-1:0]  byte index within the frame
//   out_thr[7:0]          threshold sampled with the byte's 8th bin
//   frame_done            one-cycle pulse after the last byte of a frame
//   overflow, sync_err    sticky error flags, cleared only by reset
module ate_bin_packer #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              CAL_reset,
    input  logic              in_valid,
    input  logic              sof,
    input  logic              bin,
    input  logic [7:0]        threshold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_thr,
    output logic              frame_done,
    output logic              overflow,
    output logic              sync_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H / 8 - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        PACK     = 2'd1
    } state_t;

    state_t              r_state;
    logic [2:0]          r_cnt;
    logic [7:0]          r_shift;
    logic [ADDR_W-1:0]   r_addr;
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [PTR_W:0]      r_count;
    logic                r_frame_done;
    logic                r_overflow;
    logic                r_sync_err;
    logic [7:0]          r_mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_mem_addr [FIFO_DEPTH];
    logic [7:0]          r_mem_thr  [FIFO_DEPTH];

    logic                w_restart;
    logic                w_accept;
    logic [7:0]          w_byte;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_wr_en;
    logic                w_drop;
    logic                w_last;
    logic                w_resync_bad;

    // Accept / push / pop decisions for the current edge.
    always_comb begin
        w_restart    = in_valid & sof;
        w_accept     = 1'b0;
        case (r_state)
            WAIT_SOF: w_accept = w_restart;
            PACK:     w_accept = in_valid;
            default:  w_accept = 1'b0;
        endcase
        w_byte       = {r_shift[6:0], bin};
        // A sof always starts a new byte, so it can never complete one.
        w_push       = w_accept & ~w_restart & (r_cnt == 3'd7);
        w_pop        = (r_count != {(PTR_W + 1){1'b0}}) & out_ready;
        w_full       = (r_count == FULL_CNT);
        w_wr_en      = w_push & (~w_full | w_pop);
        w_drop       = w_push & w_full & ~w_pop;
        w_last       = (r_addr == LAST_ADDR);
        // Resync is clean only on a byte boundary at byte address 0.
        w_resync_bad = (r_state == PACK) &
                       ((r_cnt != 3'd0) | (r_addr != {ADDR_W{1'b0}}));
    end

    // Packer FSM, byte addressing, FIFO storage and sticky flags.
    always_ff @(posedge clk or negedge CAL_reset) begin
        if (!CAL_reset) begin
            r_state      <= WAIT_SOF;
            r_cnt        <= 3'd0;
            r_shift      <= 8'h00;
            r_addr       <= {ADDR_W{1'b0}};
            r_wptr       <= {PTR_W{1'b0}};
            r_rptr       <= {PTR_W{1'b0}};
            r_count      <= {(PTR_W + 1){1'b0}};
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_sync_err   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= 8'h00;
                r_mem_addr[i] <= {ADDR_W{1'b0}};
                r_mem_thr[i]  <= 8'h00;
            end
        end else begin
            if (w_accept) begin
                if (w_restart) begin
                    // Any partial byte is dropped; this bin becomes bit 7 of byte 0.
                    r_state <= PACK;
                    r_shift <= {7'b0000000, bin};
                    r_cnt   <= 3'd1;
                    r_addr  <= {ADDR_W{1'b0}};
                    if (w_resync_bad) begin
                        r_sync_err <= 1'b1;
                    end else begin
                        r_sync_err <= r_sync_err;
                    end
                end else begin
                    r_shift <= w_byte;
                    r_cnt   <= r_cnt + 3'd1;
                    // Address advances even when the byte is dropped on overflow.
                    if (r_cnt == 3'd7) begin
                        r_addr <= w_last ? {ADDR_W{1'b0}} : r_addr + ADDR_W'(1);
                    end else begin
                        r_addr <= r_addr;
                    end
                end
            end else begin
                r_state <= r_state;
            end

            r_frame_done <= w_push & w_last;

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end

            if (w_wr_en) begin
                r_mem_data[r_wptr] <= w_byte;
                r_mem_addr[r_wptr] <= r_addr;
                r_mem_thr[r_wptr]  <= threshold;
                r_wptr             <= r_wptr + PTR_W'(1);
            end else begin
                r_wptr <= r_wptr;
            end

            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end else begin
                r_rptr <= r_rptr;
            end

            r_count <= r_count + {{PTR_W{1'b0}}, w_wr_en} - {{PTR_W{1'b0}}, w_pop};
        end
    end

    assign out_valid  = (r_count != {(PTR_W + 1){1'b0}});
    assign out_data   = r_mem_data[r_rptr];
    assign out_addr   = r_mem_addr[r_rptr];
    assign out_thr    = r_mem_thr[r_rptr];
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_ate_bin_packer.sv
// Self-checking bench for ate_bin_packer: table-driven byte vectors plus
// hand-written sequences, with a scoreboard queue compared on every pop.
module tb_ate_bin_packer;

    logic       clk = 1'b0;
    logic       CAL_reset;
    logic       in_valid;
    logic       sof;
    logic       bin;
    logic [7:0] threshold;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [6:0] out_addr;
    logic [7:0] out_thr;
    logic       frame_done;
    logic       overflow;
    logic       sync_err;

    ate_bin_packer #(
        .IMG_W(32), .IMG_H(32), .FIFO_DEPTH(4), .ADDR_W(7)
    ) dut (
        .clk(clk), .CAL_reset(CAL_reset), .in_valid(in_valid), .sof(sof),
        .bin(bin), .threshold(threshold), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_thr(out_thr), .frame_done(frame_done), .overflow(overflow),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [6:0] a;
        logic [7:0] t;
    } exp_t;

    typedef struct {
        logic [7:0] bits;
        logic [7:0] thr;
        logic [7:0] exp_data;
        logic [6:0] exp_addr;
    } vec_t;

    exp_t exp_q [$];
    vec_t vecs [5];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   fd_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every pop (sampled at negedge) must match the queue head.
    always @(negedge clk) begin
        if (CAL_reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pop: got data 0x%0h addr %0d, expected no output",
                         out_data, out_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pop_data", {24'h0, out_data}, {24'h0, e.d});
                check("pop_addr", {25'h0, out_addr}, {25'h0, e.a});
                check("pop_thr",  {24'h0, out_thr},  {24'h0, e.t});
            end
        end
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel; returns just after the edge that accepts it.
    task automatic send(input logic b, input logic s, input logic [7:0] t);
        in_valid  = 1'b1;
        sof       = s;
        bin       = b;
        threshold = t;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic first_sof, input logic [7:0] t);
        for (int i = 7; i >= 0; i--) begin
            send(b[i], (i == 7) && first_sof, (i == 0) ? t : 8'h00);
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        sof       = 1'b0;
        CAL_reset = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        CAL_reset = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        int         fd_before;

        vecs[0] = '{bits: 8'hB2, thr: 8'h5A, exp_data: 8'hB2, exp_addr: 7'd0};
        vecs[1] = '{bits: 8'hFF, thr: 8'h11, exp_data: 8'hFF, exp_addr: 7'd1};
        vecs[2] = '{bits: 8'h00, thr: 8'h22, exp_data: 8'h00, exp_addr: 7'd2};
        vecs[3] = '{bits: 8'h5C, thr: 8'hC3, exp_data: 8'h5C, exp_addr: 7'd3};
        vecs[4] = '{bits: 8'h81, thr: 8'hFE, exp_data: 8'h81, exp_addr: 7'd4};

        CAL_reset = 1'b0;
        in_valid  = 1'b0;
        sof       = 1'b0;
        bin       = 1'b0;
        threshold = 8'h00;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",  {31'h0, out_valid},  32'h0);
        check("rst_out_data",   {24'h0, out_data},   32'h0);
        check("rst_out_addr",   {25'h0, out_addr},   32'h0);
        check("rst_out_thr",    {24'h0, out_thr},    32'h0);
        check("rst_frame_done", {31'h0, frame_done}, 32'h0);
        check("rst_flags",      {30'h0, overflow, sync_err}, 32'h0);
        @(posedge clk);
        #1;
        CAL_reset = 1'b1;

        // Table-driven bytes with out_ready=1: each visible one cycle after its 8th bin.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{d: vecs[i].exp_data, a: vecs[i].exp_addr, t: vecs[i].thr});
            send_byte(vecs[i].bits, i == 0, vecs[i].thr);
            @(negedge clk);
            check("vec_out_valid", {31'h0, out_valid}, 32'h1);
            check("vec_out_data",  {24'h0, out_data},  {24'h0, vecs[i].exp_data});
        end
        @(negedge clk);
        check("vec_popped", {31'h0, out_valid}, 32'h0);
        check("vec_q_empty", exp_q.size(), 32'd0);

        // Full 32x32 frame of alternating bins.
        do_reset();
        fd_before = fd_count;
        for (int k = 0; k < 128; k++) begin
            exp_q.push_back('{d: 8'hAA, a: 7'(k), t: 8'(k)});
            send_byte(8'hAA, k == 0, 8'(k));
        end
        @(negedge clk);
        check("frame_done_pulse", {31'h0, frame_done}, 32'h1);
        @(negedge clk);
        check("frame_done_low", {31'h0, frame_done}, 32'h0);
        repeat (2) tick();
        check("frame_done_count", fd_count - fd_before, 32'd1);
        check("frame_q_empty", exp_q.size(), 32'd0);
        check("frame_overflow", {31'h0, overflow}, 32'h0);
        check("frame_sync_err", {31'h0, sync_err}, 32'h0);

        // Overflow: 5 bytes into a 4-deep FIFO with out_ready=0.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) exp_q.push_back('{d: 8'h10 + 8'(k), a: 7'(k), t: 8'h40 + 8'(k)});
            send_byte(8'h10 + 8'(k), k == 0, 8'h40 + 8'(k));
        end
        @(negedge clk);
        check("ovf_flag", {31'h0, overflow}, 32'h1);
        check("ovf_head_addr", {25'h0, out_addr}, 32'h0);
        repeat (3) tick();
        @(negedge clk);
        check("ovf_hold_data", {24'h0, out_data}, 32'h10);
        check("ovf_hold_thr",  {24'h0, out_thr},  32'h40);
        out_ready = 1'b1;
        repeat (6) tick();
        check("ovf_drain_empty", exp_q.size(), 32'd0);
        check("ovf_drain_valid", {31'h0, out_valid}, 32'h0);
        exp_q.push_back('{d: 8'h77, a: 7'd5, t: 8'h99});
        send_byte(8'h77, 1'b0, 8'h99);
        repeat (3) tick();
        check("ovf_next_addr_q", exp_q.size(), 32'd0);

        // Full FIFO with push and pop on the same edge.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{d: 8'h20 + 8'(k), a: 7'(k), t: 8'h50 + 8'(k)});
            send_byte(8'h20 + 8'(k), k == 0, 8'h50 + 8'(k));
        end
        exp_q.push_back('{d: 8'hE7, a: 7'd4, t: 8'h5F});
        b = 8'hE7;
        for (int i = 7; i >= 1; i--) send(b[i], 1'b0, 8'h00);
        out_ready = 1'b1;
        send(b[0], 1'b0, 8'h5F);
        out_ready = 1'b0;
        @(negedge clk);
        check("full_pp_overflow", {31'h0, overflow}, 32'h0);
        check("full_pp_valid",    {31'h0, out_valid}, 32'h1);
        check("full_pp_head",     {25'h0, out_addr}, 32'h1);
        out_ready = 1'b1;
        repeat (6) tick();
        check("full_pp_q_empty", exp_q.size(), 32'd0);

        // sof mid-byte: partial byte discarded, sync_err set.
        do_reset();
        out_ready = 1'b1;
        send(1'b1, 1'b1, 8'h00);
        send(1'b1, 1'b0, 8'h00);
        send(1'b1, 1'b0, 8'h00);
        exp_q.push_back('{d: 8'h00, a: 7'd0, t: 8'h33});
        send_byte(8'h00, 1'b1, 8'h33);
        repeat (3) tick();
        check("sync_err_set", {31'h0, sync_err}, 32'h1);
        check("sync_q_empty", exp_q.size(), 32'd0);

        // Asynchronous reset with 3 bytes queued and a partial byte.
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back('{d: 8'h30 + 8'(k), a: 7'(k), t: 8'h60 + 8'(k)});
            send_byte(8'h30 + 8'(k), 1'b0, 8'h60 + 8'(k));
        end
        send(1'b1, 1'b0, 8'h00);
        send(1'b0, 1'b0, 8'h00);
        send(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        tick();
        CAL_reset = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, out_valid}, 32'h0);
        check("async_rst_flags", {30'h0, overflow, sync_err}, 32'h0);
        exp_q.delete();
        #2;
        CAL_reset = 1'b1;
        out_ready = 1'b1;
        send_byte(8'hFF, 1'b0, 8'h00);
        repeat (3) tick();
        check("no_sof_ignored", {31'h0, out_valid}, 32'h0);
        exp_q.push_back('{d: 8'hC3, a: 7'd0, t: 8'h44});
        send_byte(8'hC3, 1'b1, 8'h44);
        repeat (3) tick();
        check("post_rst_q_empty", exp_q.size(), 32'd0);
        check("post_rst_flags", {30'h0, overflow, sync_err}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
